demm_result_packer: RTL and testbench

//  Downstream stage of the DEMM dot-product kernel. Consumes the fp64 dot-product result stream.

---
 rtl/demm_pkg.sv | 28 ++
 rtl/fp64_to_fp16_conv.sv | 105 ++++++++++
 rtl/demm_result_packer.sv | 167 ++++++++++++++++
 tb/tb_demm_result_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demm_pkg.sv
// Shared definitions for the DEMM result packer.
//  - exponent biases and the fp16 special encodings
//  - fp16_t / fp64_t scalar types and the per-result exception flags struct
//  - eff_cols(): row length with 0 mapped to 1
package demm_pkg;

  localparam int FP64_EXP_BIAS = 1023;
  localparam int FP16_EXP_BIAS = 15;

  typedef logic [15:0] fp16_t;
  typedef logic [63:0] fp64_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;
  localparam fp16_t FP16_INF  = 16'h7C00;
  localparam fp16_t FP16_MAX  = 16'h7BFF;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic nan;
  } conv_flags_t;

  // A row length of zero is meaningless; treat it as a one-result row.
  function automatic logic [31:0] eff_cols(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/fp64_to_fp16_conv.sv
// Combinational IEEE fp64 -> fp16 converter, round-to-nearest-even.
// Ports:
//  din   in  fp64 value
//  dout  out fp16 value
//  flags out {ovf, unf, nan} raised by this conversion
// Build option: DEMM_PACK_SAT_EN defined -> overflow saturates to +/-65504,
//               otherwise overflow produces +/-inf.
module fp64_to_fp16_conv
  import demm_pkg::*;
(
  input  fp64_t       din,
  output fp16_t       dout,
  output conv_flags_t flags
);

  localparam logic [10:0] EXP_MAX     = 11'h7FF;
  localparam logic [10:0] EXP_OVF_MIN = 11'(FP64_EXP_BIAS + 16);  // e > 15
  localparam logic [10:0] EXP_NRM_MIN = 11'(FP64_EXP_BIAS - 14);  // e >= -14
  localparam logic [10:0] EXP_SUB_MIN = 11'(FP64_EXP_BIAS - 25);  // e >= -25
  localparam logic [10:0] EXP_REBIAS  = 11'(FP64_EXP_BIAS - FP16_EXP_BIAS);
  // Subnormal right shift of the 53-bit significand is 28 - e = (1023 + 28) - exp64.
  localparam logic [10:0] SUB_SH_BASE = 11'(FP64_EXP_BIAS + 28);

`ifdef DEMM_PACK_SAT_EN
  localparam logic [14:0] OVF_MAG = FP16_MAX[14:0];
`else
  localparam logic [14:0] OVF_MAG = FP16_INF[14:0];
`endif

  logic        sgn;
  logic [10:0] exp64;
  logic [51:0] mant;
  logic [52:0] sig;

  assign sgn   = din[63];
  assign exp64 = din[62:52];
  assign mant  = din[51:0];
  assign sig   = {1'b1, mant};

  // Normal range: keep the top 10 mantissa bits; the round-up carry ripples
  // into the exponent field naturally, and exponent 31 means overflow.
  logic [4:0]  nrm_exp;
  logic        nrm_g;
  logic        nrm_st;
  logic        nrm_up;
  logic [14:0] nrm_v;

  assign nrm_exp = 5'(exp64 - EXP_REBIAS);
  assign nrm_g   = mant[41];
  assign nrm_st  = |mant[40:0];
  assign nrm_up  = nrm_g & (nrm_st | mant[42]);
  assign nrm_v   = {nrm_exp, mant[51:42]} + 15'(nrm_up);

  // Subnormal range: shift 43..53 places; guard is the bit just below the
  // kept field, sticky is everything under the guard. A carry to 0x400
  // lands exactly on the smallest normal encoding.
  logic [5:0]  sub_sh;
  logic [9:0]  sub_q;
  logic [52:0] sub_gbit;
  logic [52:0] sub_mask;
  logic        sub_g;
  logic        sub_st;
  logic        sub_up;
  logic [10:0] sub_v;

  assign sub_sh   = 6'(SUB_SH_BASE - exp64);
  assign sub_q    = 10'(sig >> sub_sh);
  assign sub_gbit = 53'd1 << (sub_sh - 6'd1);
  assign sub_mask = sub_gbit - 53'd1;
  assign sub_g    = |(sig & sub_gbit);
  assign sub_st   = |(sig & sub_mask);
  assign sub_up   = sub_g & (sub_st | sub_q[0]);
  assign sub_v    = {1'b0, sub_q} + 11'(sub_up);

  always_comb begin
    dout  = {sgn, 15'd0};
    flags = '0;
    if (exp64 == EXP_MAX) begin
      if (mant != 52'd0) begin
        dout      = {sgn, FP16_QNAN[14:0]};
        flags.nan = 1'b1;
      end else begin
        dout = {sgn, FP16_INF[14:0]};
      end
    end else if (exp64 == 11'd0) begin
      flags.unf = (mant != 52'd0);
    end else if (exp64 >= EXP_OVF_MIN) begin
      dout      = {sgn, OVF_MAG};
      flags.ovf = 1'b1;
    end else if (exp64 >= EXP_NRM_MIN) begin
      if (nrm_v[14:10] == 5'h1F) begin
        dout      = {sgn, OVF_MAG};
        flags.ovf = 1'b1;
      end else begin
        dout = {sgn, nrm_v};
      end
    end else if (exp64 >= EXP_SUB_MIN) begin
      dout      = {sgn, 4'd0, sub_v};
      flags.unf = (sub_v == 11'd0);
    end else begin
      flags.unf = 1'b1;
    end
  end

endmodule

// File: rtl/demm_result_packer.sv
// DEMM result packer: converts the fp64 dot-product stream to fp16 and packs
// PACK_N results per AXIS beat, marking the beat that ends a row.
// Ports:
//  clk, rst              clock, asynchronous active-high reset
//  cols_num              results per row (0 treated as 1), sampled at row start
//  clr_flags             clears the sticky flags (a same-cycle event wins)
//  s_tdata/s_tvalid/s_tready   fp64 input stream
//  m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready  packed fp16 output stream
//  flag_ovf/flag_unf/flag_nan  sticky exception flags
// Build option: DEMM_PACK_SAT_EN (see fp64_to_fp16_conv) selects saturation
// instead of infinity on overflow.
module demm_result_packer
  import demm_pkg::*;
#(
  parameter int PACK_N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cols_num,
  input  logic                  clr_flags,
  input  logic [63:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [PACK_N*16-1:0]  m_tdata,
  output logic [PACK_N*2-1:0]   m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  flag_ovf,
  output logic                  flag_unf,
  output logic                  flag_nan
);

  localparam int LW = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(PACK_N - 1);

  fp16_t       conv_data;
  conv_flags_t conv_flags;

  fp64_to_fp16_conv u_conv (
    .din   (s_tdata),
    .dout  (conv_data),
    .flags (conv_flags)
  );

  logic                 c_valid_reg;
  fp16_t                c_data_reg;
  logic [LW-1:0]        lane_reg;
  logic [31:0]          col_reg;
  logic [31:0]          row_cols_reg;
  logic [31:0]          cols_cur;
  logic                 lane_last;
  logic                 row_last;
  logic                 done;
  logic                 out_free;
  logic                 s_fire;
  logic                 c_fire;
  logic [PACK_N*16-1:0] beat_data;
  logic [PACK_N*2-1:0]  beat_keep;
  logic [PACK_N*16-1:0] m_tdata_reg;
  logic [PACK_N*2-1:0]  m_tkeep_reg;
  logic                 m_tlast_reg;
  logic                 m_tvalid_reg;
  logic                 flag_ovf_reg;
  logic                 flag_unf_reg;
  logic                 flag_nan_reg;

  // The first result of a row sees the live cols_num; the rest of the row
  // uses the value latched at that moment.
  assign cols_cur  = (col_reg == 32'd0) ? eff_cols(cols_num) : row_cols_reg;
  assign lane_last = (lane_reg == LANE_LAST);
  assign row_last  = (col_reg == cols_cur - 32'd1);
  assign done      = lane_last || row_last;
  assign out_free  = !m_tvalid_reg || m_tready;
  assign c_fire    = c_valid_reg && (!done || out_free);
  assign s_tready  = !c_valid_reg || c_fire;
  assign s_fire    = s_tvalid && s_tready;

  // Converter output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid_reg <= 1'b0;
      c_data_reg  <= '0;
    end else if (s_fire) begin
      c_valid_reg <= 1'b1;
      c_data_reg  <= conv_data;
    end else if (c_fire) begin
      c_valid_reg <= 1'b0;
    end
  end

  // Pack buffer. Lanes above the current one are always zero because the
  // buffer is cleared whenever a beat leaves, so the outgoing beat is just
  // the buffer with the current lane overlaid.
  genvar gi;
  generate
    for (gi = 0; gi < PACK_N; gi++) begin : g_lane
      logic [15:0] word_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (c_fire) begin
          if (done) begin
            word_reg <= '0;
          end else if (lane_reg == LW'(gi)) begin
            word_reg <= c_data_reg;
          end
        end
      end
      assign beat_data[gi*16 +: 16] = (lane_reg == LW'(gi)) ? c_data_reg : word_reg;
      assign beat_keep[gi*2 +: 2]   = (LW'(gi) <= lane_reg) ? 2'b11 : 2'b00;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_reg     <= '0;
      col_reg      <= '0;
      row_cols_reg <= 32'd1;
    end else if (c_fire) begin
      lane_reg <= done ? '0 : lane_reg + LW'(1);
      col_reg  <= row_last ? 32'd0 : col_reg + 32'd1;
      if (col_reg == 32'd0) begin
        row_cols_reg <= eff_cols(cols_num);
      end
    end
  end

  // Output register: only reloaded when free, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tlast_reg  <= 1'b0;
    end else if (c_fire && done) begin
      m_tvalid_reg <= 1'b1;
      m_tdata_reg  <= beat_data;
      m_tkeep_reg  <= beat_keep;
      m_tlast_reg  <= row_last;
    end else if (m_tready) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_ovf_reg <= 1'b0;
      flag_unf_reg <= 1'b0;
      flag_nan_reg <= 1'b0;
    end else begin
      flag_ovf_reg <= (flag_ovf_reg && !clr_flags) || (s_fire && conv_flags.ovf);
      flag_unf_reg <= (flag_unf_reg && !clr_flags) || (s_fire && conv_flags.unf);
      flag_nan_reg <= (flag_nan_reg && !clr_flags) || (s_fire && conv_flags.nan);
    end
  end

  assign m_tdata  = m_tdata_reg;
  assign m_tkeep  = m_tkeep_reg;
  assign m_tlast  = m_tlast_reg;
  assign m_tvalid = m_tvalid_reg;
  assign flag_ovf = flag_ovf_reg;
  assign flag_unf = flag_unf_reg;
  assign flag_nan = flag_nan_reg;

endmodule

// File: tb/tb_demm_result_packer.sv
// Directed bench for demm_result_packer (PACK_N=4).
// Honours DEMM_PACK_SAT_EN for the expected overflow encoding.
module tb_demm_result_packer;

`ifdef DEMM_PACK_SAT_EN
  localparam logic [15:0] OVF_P = 16'h7BFF;
  localparam logic [15:0] OVF_N = 16'hFBFF;
`else
  localparam logic [15:0] OVF_P = 16'h7C00;
  localparam logic [15:0] OVF_N = 16'hFC00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cols_num;
  logic        clr_flags;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_nan;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;
  beat_t beatq[$];

  demm_result_packer #(.PACK_N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cols_num  (cols_num),
    .clr_flags (clr_flags),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_nan  (flag_nan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only just after a rising edge, so a beat seen valid and
  // ready at the falling edge is the one transferred on the next rising edge.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beatq.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
      $display("beat data=%h keep=%h last=%b", m_tdata, m_tkeep, m_tlast);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] v);
    int n;
    n = 0;
    s_tdata  = v;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 300) begin
        chk("push_timeout", 64'(s_tready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] d,
                             input logic [7:0] k, input logic l);
    beat_t b;
    int    n;
    n = 0;
    while (beatq.size() == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_arrived"}, 64'(beatq.size() != 0), 64'd1);
    if (beatq.size() != 0) begin
      b = beatq.pop_front();
      chk({tag, "_data"}, b.d, d);
      chk({tag, "_keep"}, 64'(b.k), 64'(k));
      chk({tag, "_last"}, 64'(b.l), 64'(l));
    end
  endtask

  initial begin
    rst       = 1'b1;
    cols_num  = 32'd4;
    clr_flags = 1'b0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mdata", m_tdata, 64'd0);
    chk("rst_mkeep", 64'(m_tkeep), 64'd0);
    chk("rst_mlast", 64'(m_tlast), 64'd0);
    chk("rst_flags", 64'({flag_ovf, flag_unf, flag_nan}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sready", 64'(s_tready), 64'd1);

    // 1: basic beat and latency
    push(64'h3FF0000000000000);
    push(64'h4000000000000000);
    push(64'hBFE0000000000000);
    push(64'h40EFFC0000000000);
    chk("t1_lat_c", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_lat_out", 64'(m_tvalid), 64'd1);
    expect_beat("t1", 64'h7BFF_B800_4000_3C00, 8'hFF, 1'b1);

    // 2: rounding
    push(64'h3FF0020000000000);
    push(64'h3FF0060000000000);
    push(64'h3E70000000000000);
    chk("t2_unf_before", 64'(flag_unf), 64'd0);
    push(64'h3E50000000000000);
    chk("t2_unf_after", 64'(flag_unf), 64'd1);
    expect_beat("t2", 64'h0000_0001_3C02_3C00, 8'hFF, 1'b1);

    // 3: exceptions and flag clearing
    chk("t3_ovf_before", 64'(flag_ovf), 64'd0);
    push(64'h40F86A0000000000);
    chk("t3_ovf", 64'(flag_ovf), 64'd1);
    push(64'h7FF8000000000000);
    chk("t3_nan", 64'(flag_nan), 64'd1);
    push(64'h3FF0000000000000);
    push(64'h0000000000000000);
    expect_beat("t3", {16'h0000, 16'h3C00, 16'h7E00, OVF_P}, 8'hFF, 1'b1);
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    chk("t3_clr", 64'({flag_ovf, flag_unf, flag_nan}), 64'd0);
    push(64'hC0F86A0000000000);
    clr_flags = 1'b1;
    push(64'h3E50000000000000);
    clr_flags = 1'b0;
    chk("t3_clr_ovf", 64'(flag_ovf), 64'd0);
    chk("t3_clr_set_unf", 64'(flag_unf), 64'd1);
    push(64'h3FF0000000000000);
    push(64'h3FF0000000000000);
    expect_beat("t3b", {16'h3C00, 16'h3C00, 16'h0000, OVF_N}, 8'hFF, 1'b1);

    // 4: partial beat, cols_num=0
    cols_num = 32'd6;
    push(64'h3FF0000000000000);
    push(64'h4000000000000000);
    push(64'hBFE0000000000000);
    push(64'h3FE0000000000000);
    push(64'h4008000000000000);
    push(64'hC000000000000000);
    expect_beat("t4a", 64'h3800_B800_4000_3C00, 8'hFF, 1'b0);
    expect_beat("t4b", 64'h0000_0000_C000_4200, 8'h0F, 1'b1);
    cols_num = 32'd4;
    push(64'h4000000000000000);
    push(64'h3FF0000000000000);
    push(64'h4000000000000000);
    push(64'h3FF0000000000000);
    expect_beat("t4c", 64'h3C00_4000_3C00_4000, 8'hFF, 1'b1);
    cols_num = 32'd0;
    push(64'h3FF0000000000000);
    expect_beat("t4z", 64'h0000_0000_0000_3C00, 8'h03, 1'b1);
    cols_num = 32'd4;

    // 5: backpressure
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) push($realtobits(real'(i + 1)));
      end
      begin : ctl
        logic [63:0] held;
        bit          seen;
        seen = 1'b0;
        held = '0;
        repeat (10) begin
          @(posedge clk);
          #1;
          if (m_tvalid) begin
            if (!seen) begin
              held = m_tdata;
              seen = 1'b1;
              chk("t5_stall_first", held, 64'h4400_4200_4000_3C00);
            end else begin
              chk("t5_stall_stable", m_tdata, held);
            end
          end
        end
        chk("t5_stall_mvalid", 64'(m_tvalid), 64'd1);
        chk("t5_stall_sready", 64'(s_tready), 64'd0);
        for (int k = 0; k < 600 && beatq.size() < 3; k++) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    expect_beat("t5a", 64'h4400_4200_4000_3C00, 8'hFF, 1'b1);
    expect_beat("t5b", 64'h4800_4700_4600_4500, 8'hFF, 1'b1);
    expect_beat("t5c", 64'h4A00_4980_4900_4880, 8'hFF, 1'b1);
    begin : thr
      int c0;
      c0 = cyc;
      for (int i = 0; i < 4; i++) push($realtobits(real'(i + 5)));
      chk("t5_throughput", 64'(cyc - c0), 64'd4);
    end
    expect_beat("t5d", 64'h4800_4700_4600_4500, 8'hFF, 1'b1);
    chk("t5_no_extra", 64'(beatq.size()), 64'd0);

    // 6: reset mid-row
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) push($realtobits(real'(i + 1)));
    push(64'h4014000000000000);
    push(64'h7FF8000000000000);
    @(posedge clk);
    #1;
    chk("t6_pre_mvalid", 64'(m_tvalid), 64'd1);
    chk("t6_pre_nan", 64'(flag_nan), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_flags", 64'({flag_ovf, flag_unf, flag_nan}), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_tready = 1'b1;
    beatq.delete();
    for (int i = 0; i < 4; i++) push($realtobits(real'(i + 9)));
    expect_beat("t6", 64'h4A00_4980_4900_4880, 8'hFF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_extra", 64'(beatq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
